// File: rtl/count_pkg.sv
// count_pkg: mode constants and parameter legality check for count_mod
package count_pkg;
  localparam logic CNT_WRAP = 1'b0;
  localparam logic CNT_SAT = 1'b1;
  function automatic bit cnt_modulus_ok(input int width, input longint modulus);
    return modulus >= 2 && modulus <= (longint'(1) << width);
  endfunction
endpackage

// File: rtl/count_if.sv
// count_if: control, compare and status signals of count_mod
interface count_if #(parameter int WIDTH = 4);
  logic en;
  logic dec;
  logic load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] cmp_val;
  logic [WIDTH-1:0] count;
  logic tc;
  logic match;
  modport master (output en, dec, load, load_val, cmp_val, input count, tc, match);
  modport slave (input en, dec, load, load_val, cmp_val, output count, tc, match);
endinterface

// File: rtl/count_step.sv
// count_step: next counter value and boundary hit, computed one bit wider than the count
module count_step
  import count_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MODULUS = 16
) (
  input  logic [WIDTH-1:0] count,
  input  logic             dec,
  input  logic             mode,
  output logic [WIDTH-1:0] nxt,
  output logic             hit
);
  localparam logic [WIDTH:0] MAX = (WIDTH+1)'(MODULUS - 1);
  logic [WIDTH:0] c;
  logic [WIDTH:0] n;
  assign c = {1'b0, count};
  assign hit = dec ? (c == '0) : (c == MAX);
  assign n = hit ? (mode == CNT_SAT ? c : (dec ? MAX : '0)) : (dec ? c - 1'b1 : c + 1'b1);
  assign nxt = WIDTH'(n);
endmodule

// File: rtl/count_mod.sv
// count_mod: up/down modulus counter with wrap/saturate, load clamp, terminal-count pulse and compare match
module count_mod
  import count_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MODULUS = 16,
  parameter int SATURATE = 0,
  parameter int RESET_VAL = 0
) (
  input logic   clk,
  input logic   reset,
  count_if.slave bus
);
  localparam logic [WIDTH:0] MAX = (WIDTH+1)'(MODULUS - 1);
  localparam logic MODE = (SATURATE != 0) ? CNT_SAT : CNT_WRAP;
  if (!cnt_modulus_ok(WIDTH, longint'(MODULUS)) || RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_param
    $error("count_mod: illegal MODULUS or RESET_VAL");
  end
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] clamp;
  logic             hit;
  logic             tc_q;
  count_step #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_step (
    .count(cnt),
    .dec  (bus.dec),
    .mode (MODE),
    .nxt  (nxt),
    .hit  (hit)
  );
  assign clamp = ({1'b0, bus.load_val} > MAX) ? WIDTH'(MAX) : bus.load_val;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= WIDTH'(RESET_VAL);
      tc_q <= 1'b0;
    end else if (bus.load) begin
      cnt <= clamp;
      tc_q <= 1'b0;
    end else if (bus.en) begin
      cnt <= nxt;
      tc_q <= hit;
    end else begin
      tc_q <= 1'b0;
    end
  end
  assign bus.count = cnt;
  assign bus.tc = tc_q;
  assign bus.match = (cnt == bus.cmp_val);
endmodule

// File: tb/tb_count_mod.sv
// tb_count_mod: scoreboard bench over three count_mod configurations
module tb_count_mod;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  count_if #(.WIDTH(4)) ia ();
  count_if #(.WIDTH(4)) ib ();
  count_if #(.WIDTH(4)) ic ();
  count_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RESET_VAL(3)) u_a (.clk(clk), .reset(reset), .bus(ia));
  count_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(1), .RESET_VAL(0)) u_b (.clk(clk), .reset(reset), .bus(ib));
  count_mod #(.WIDTH(4), .MODULUS(12), .SATURATE(1), .RESET_VAL(0)) u_c (.clk(clk), .reset(reset), .bus(ic));
  typedef struct {int w; int cnt; int tc; int cmp;} exp_t;
  exp_t sb[$];
  int mods[3] = '{10, 16, 12};
  int sats[3] = '{0, 1, 1};
  int rvs[3] = '{3, 0, 0};
  int m[3] = '{3, 0, 0};
  int cmps[3] = '{0, 0, 0};
  task automatic chk(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask
  function automatic int get_cnt(input int w);
    return w == 0 ? int'(ia.count) : w == 1 ? int'(ib.count) : int'(ic.count);
  endfunction
  function automatic int get_tc(input int w);
    return w == 0 ? int'(ia.tc) : w == 1 ? int'(ib.tc) : int'(ic.tc);
  endfunction
  function automatic int get_match(input int w);
    return w == 0 ? int'(ia.match) : w == 1 ? int'(ib.match) : int'(ic.match);
  endfunction
  task automatic set_cmp(input int w, input int v);
    cmps[w] = v;
    case (w)
      0: ia.cmp_val = 4'(v);
      1: ib.cmp_val = 4'(v);
      default: ic.cmp_val = 4'(v);
    endcase
  endtask
  task automatic set_in(input int w, input bit en, input bit dec, input bit ld, input int lv);
    case (w)
      0: begin ia.en = en; ia.dec = dec; ia.load = ld; ia.load_val = 4'(lv); end
      1: begin ib.en = en; ib.dec = dec; ib.load = ld; ib.load_val = 4'(lv); end
      default: begin ic.en = en; ic.dec = dec; ic.load = ld; ic.load_val = 4'(lv); end
    endcase
  endtask
  task automatic step(input int w, input bit en, input bit dec, input bit ld, input int lv);
    exp_t e;
    int top;
    int t;
    top = mods[w] - 1;
    t = 0;
    if (ld) m[w] = (lv > top) ? top : lv;
    else if (en && !dec) begin
      if (m[w] == top) begin t = 1; m[w] = sats[w] ? top : 0; end
      else m[w] = m[w] + 1;
    end else if (en && dec) begin
      if (m[w] == 0) begin t = 1; m[w] = sats[w] ? 0 : top; end
      else m[w] = m[w] - 1;
    end
    set_in(w, en, dec, ld, lv);
    sb.push_back('{w, m[w], t, cmps[w]});
    @(posedge clk);
    #1;
    set_in(w, 1'b0, 1'b0, 1'b0, 0);
    e = sb.pop_front();
    chk($sformatf("cnt%0d", e.w), get_cnt(e.w), e.cnt);
    chk($sformatf("tc%0d", e.w), get_tc(e.w), e.tc);
    chk($sformatf("match%0d", e.w), get_match(e.w), int'(e.cnt == e.cmp));
  endtask
  initial begin
    for (int w = 0; w < 3; w++) begin
      set_in(w, 1'b0, 1'b0, 1'b0, 0);
      set_cmp(w, 0);
    end
    #12;
    chk("rst_cnt_a", get_cnt(0), 3);
    chk("rst_tc_a", get_tc(0), 0);
    chk("rst_cnt_b", get_cnt(1), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 8);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    chk("wrap_up_end", get_cnt(0), 1);
    step(0, 0, 0, 1, 0);
    step(0, 1, 1, 0, 0);
    chk("wrap_dn_tc", get_tc(0), 1);
    step(0, 1, 0, 1, 5);
    chk("prio_load", get_cnt(0), 5);
    step(1, 0, 0, 1, 14);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
    step(1, 0, 1, 1, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(2, 0, 0, 1, 15);
    chk("clamp", get_cnt(2), 11);
    step(0, 0, 0, 1, 9);
    step(0, 1, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    for (int w = 0; w < 3; w++) m[w] = rvs[w];
    chk("async_cnt", get_cnt(0), 3);
    chk("async_tc", get_tc(0), 0);
    chk("async_cnt_c", get_cnt(2), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    set_cmp(0, 7);
    step(0, 0, 0, 1, 5);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    set_cmp(0, 8);
    #1 chk("match_cmb_hit", get_match(0), 1);
    set_cmp(0, 3);
    #1 chk("match_cmb_miss", get_match(0), 0);
    for (int i = 0; i < 300; i++) begin
      int w;
      w = $urandom_range(2);
      if ($urandom_range(7) == 0) set_cmp(w, $urandom_range(15));
      step(w, 1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(9) == 0, $urandom_range(15));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
